// File: rtl/et_chord_sequencer.sv
// Ear-training chord arpeggiator: plays up to three latched note IDs in turn on one freq_pwm tone generator.
// Optional feature: define SEQ_LOOP_EN to replay the chord while loop_en is held high.
module et_chord_sequencer #(
    parameter int unsigned NOTE_CLKS = 50000000,
    parameter int unsigned GAP_CLKS  = 10000000,
    parameter int unsigned OCT_SHIFT = 3,
    parameter int unsigned ID_OFFSET = 27
) (
    input  logic        CLK100MHZ,
    input  logic        rst,
    input  logic        start,
    input  logic        abort,
    input  logic        loop_en,
    input  logic [1:0]  note_num,
    input  logic [6:0]  note_id_0,
    input  logic [6:0]  note_id_1,
    input  logic [6:0]  note_id_2,
    output logic [31:0] clks_per_period,
    output logic        new_period,
    output logic        tone_en,
    output logic        busy,
    output logic        done,
    output logic [1:0]  cur_idx
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_PLAY,
        S_GAP,
        S_DONE
    } state_t;

    state_t      state_reg, state_next;
    logic [31:0] cnt_reg;
    logic [1:0]  cur_idx_reg, cur_idx_next;
    logic [1:0]  num_reg;
    logic [31:0] clks_reg;
    logic [6:0]  ids_reg [3];
    logic [6:0]  id_in   [3];

    logic        accept;
    logic [6:0]  cur_id;
    logic [6:0]  octid;
    logic        note_valid;
    logic [31:0] base_period;
    logic        more_notes;

`ifndef SEQ_LOOP_EN
    logic unused_loop_en;
    assign unused_loop_en = loop_en;
`endif

    assign id_in[0] = note_id_0;
    assign id_in[1] = note_id_1;
    assign id_in[2] = note_id_2;

    // Abort beats start when both arrive in IDLE.
    assign accept = (state_reg == S_IDLE) && start && !abort;

    genvar gi;
    generate
        for (gi = 0; gi < 3; gi++) begin : g_id_latch
            always_ff @(posedge CLK100MHZ) begin
                if (rst) begin
                    ids_reg[gi] <= '0;
                end else if (accept) begin
                    ids_reg[gi] <= id_in[gi];
                end
            end
        end
    endgenerate

    always_comb begin
        cur_id = '0;
        case (cur_idx_reg)
            2'd0:    cur_id = ids_reg[0];
            2'd1:    cur_id = ids_reg[1];
            2'd2:    cur_id = ids_reg[2];
            default: cur_id = '0;
        endcase
    end

    // IDs below the offset wrap to large values and fall outside 1..12.
    assign octid      = cur_id - 7'(ID_OFFSET);
    assign note_valid = (octid >= 7'd1) && (octid <= 7'd12);
    assign more_notes = ({1'b0, cur_idx_reg} + 3'd1) < {1'b0, num_reg};

    always_comb begin
        base_period = '0;
        case (octid)
            7'd1:    base_period = 32'd3057805;
            7'd2:    base_period = 32'd2886184;
            7'd3:    base_period = 32'd2724194;
            7'd4:    base_period = 32'd2571298;
            7'd5:    base_period = 32'd2426982;
            7'd6:    base_period = 32'd2290765;
            7'd7:    base_period = 32'd2162195;
            7'd8:    base_period = 32'd2040840;
            7'd9:    base_period = 32'd1926296;
            7'd10:   base_period = 32'd1818182;
            7'd11:   base_period = 32'd1716135;
            7'd12:   base_period = 32'd1619816;
            default: base_period = '0;
        endcase
    end

    always_ff @(posedge CLK100MHZ) begin
        if (rst) begin
            state_reg   <= S_IDLE;
            cnt_reg     <= '0;
            cur_idx_reg <= '0;
            num_reg     <= '0;
            clks_reg    <= '0;
        end else begin
            state_reg   <= state_next;
            cnt_reg     <= (state_next != state_reg) ? 32'd0 : cnt_reg + 32'd1;
            cur_idx_reg <= cur_idx_next;
            if (accept) begin
                num_reg <= note_num;
            end
            if ((state_reg == S_LOAD) && note_valid) begin
                clks_reg <= base_period >> OCT_SHIFT;
            end
        end
    end

    always_comb begin
        state_next   = state_reg;
        cur_idx_next = cur_idx_reg;
        case (state_reg)
            S_IDLE: begin
                if (accept) begin
                    cur_idx_next = '0;
                    state_next   = (note_num == 2'd0) ? S_DONE : S_LOAD;
                end
            end
            S_LOAD: begin
                // Invalid notes are skipped here without spending a tone or gap.
                if (note_valid) begin
                    state_next = S_PLAY;
                end else if (more_notes) begin
                    cur_idx_next = cur_idx_reg + 2'd1;
                end else begin
                    state_next = S_DONE;
                end
            end
            S_PLAY: begin
                if (cnt_reg == 32'(NOTE_CLKS - 1)) begin
                    state_next = S_GAP;
                end
            end
            S_GAP: begin
                if (cnt_reg == 32'(GAP_CLKS - 1)) begin
                    if (more_notes) begin
                        cur_idx_next = cur_idx_reg + 2'd1;
                        state_next   = S_LOAD;
`ifdef SEQ_LOOP_EN
                    end else if (loop_en) begin
                        cur_idx_next = '0;
                        state_next   = S_LOAD;
`endif
                    end else begin
                        state_next = S_DONE;
                    end
                end
            end
            S_DONE: begin
                state_next = S_IDLE;
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
        if (abort && (state_reg != S_IDLE)) begin
            state_next = S_IDLE;
        end
    end

    always_comb begin
        tone_en         = (state_reg == S_PLAY);
        new_period      = (state_reg == S_PLAY) && (cnt_reg == 32'd0);
        busy            = (state_reg != S_IDLE);
        done            = (state_reg == S_DONE);
        clks_per_period = clks_reg;
        cur_idx         = cur_idx_reg;
    end

endmodule

// File: tb/tb_et_chord_sequencer.sv
// Scoreboard bench for et_chord_sequencer: stimulus queues expected pulses, a negedge monitor consumes them.
module tb_et_chord_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        abort;
    logic        loop_en;
    logic [1:0]  note_num;
    logic [6:0]  note_id_0, note_id_1, note_id_2;
    logic [31:0] clks_per_period;
    logic        new_period, tone_en, busy, done;
    logic [1:0]  cur_idx;

    always #5 clk = ~clk;

    et_chord_sequencer #(
        .NOTE_CLKS(8),
        .GAP_CLKS (4),
        .OCT_SHIFT(3),
        .ID_OFFSET(27)
    ) dut (
        .CLK100MHZ      (clk),
        .rst            (rst),
        .start          (start),
        .abort          (abort),
        .loop_en        (loop_en),
        .note_num       (note_num),
        .note_id_0      (note_id_0),
        .note_id_1      (note_id_1),
        .note_id_2      (note_id_2),
        .clks_per_period(clks_per_period),
        .new_period     (new_period),
        .tone_en        (tone_en),
        .busy           (busy),
        .done           (done),
        .cur_idx        (cur_idx)
    );

    typedef struct {
        int          c;
        logic [31:0] p;
    } np_t;

    np_t np_q[$];
    int  done_q[$];
    int  tone_q[$];
    int  checks   = 0;
    int  failures = 0;
    int  cyc      = 0;
    int  run_len  = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: every new_period, done pulse and completed tone burst consumes one expectation.
    always @(negedge clk) begin
        if (new_period) begin
            check("np_pending", np_q.size() > 0, 1);
            if (np_q.size() > 0) begin
                np_t e;
                e = np_q.pop_front();
                check("np_cycle", cyc, e.c);
                check("np_clks", clks_per_period, e.p);
                check("np_tone", tone_en, 1);
            end
        end
        if (done) begin
            check("done_pending", done_q.size() > 0, 1);
            if (done_q.size() > 0) begin
                int e;
                e = done_q.pop_front();
                check("done_cycle", cyc, e);
                check("done_tone", tone_en, 0);
            end
        end
        if (tone_en) begin
            run_len++;
        end else if (run_len > 0) begin
            check("tone_pending", tone_q.size() > 0, 1);
            if (tone_q.size() > 0) begin
                int e;
                e = tone_q.pop_front();
                check("tone_len", run_len, e);
            end
            run_len = 0;
        end
    end

    task automatic wait_until(input int c);
        while (cyc < c) @(negedge clk);
    endtask

    task automatic wait_idle(input int limit);
        int n;
        n = 0;
        while (busy && n < limit) begin
            @(negedge clk);
            n++;
        end
        check("idle_within_budget", busy, 0);
    endtask

    // Periods are hand-computed BASE[id-27]>>3; a zero period marks a note expected to be skipped.
    task automatic issue(input logic [1:0] num, input logic [6:0] a, input logic [6:0] b,
                         input logic [6:0] c, input logic [31:0] pa, input logic [31:0] pb,
                         input logic [31:0] pc, output int t0);
        logic [31:0] per [3];
        int t;
        per[0] = pa;
        per[1] = pb;
        per[2] = pc;
        @(negedge clk);
        note_num  = num;
        note_id_0 = a;
        note_id_1 = b;
        note_id_2 = c;
        start     = 1'b1;
        t0        = cyc;
        t         = t0 + 1;
        for (int i = 0; i < int'(num); i++) begin
            if (per[i] != 0) begin
                np_q.push_back('{t + 1, per[i]});
                tone_q.push_back(8);
                t = t + 13;
            end else begin
                t = t + 1;
            end
        end
        done_q.push_back(t);
        @(negedge clk);
        start = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog cycle=%0d required=finish", cyc);
        $fatal(1, "watchdog expired");
    end

    initial begin
        int t0;
        rst = 1'b1; start = 1'b0; abort = 1'b0; loop_en = 1'b0;
        note_num = '0; note_id_0 = '0; note_id_1 = '0; note_id_2 = '0;
        repeat (3) @(negedge clk);
        check("rst_clks", clks_per_period, 0);
        check("rst_np", new_period, 0);
        check("rst_tone", tone_en, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_idx", cur_idx, 0);
        rst = 1'b0;
        @(negedge clk);

        // Three valid notes.
        issue(2'd3, 7'd28, 7'd37, 7'd39, 32'd382225, 32'd227272, 32'd202477, t0);
        check("t1_load_busy", busy, 1);
        wait_until(t0 + 5);
        check("t1_tone_mid", tone_en, 1);
        check("t1_idx0", cur_idx, 0);
        wait_until(t0 + 11);
        check("t1_gap_tone", tone_en, 0);
        check("t1_gap_clks", clks_per_period, 382225);
        wait_until(t0 + 16);
        check("t1_idx1", cur_idx, 1);
        wait_idle(100);
        check("t1_idle_cycle", cyc, t0 + 41);

        // First note invalid and skipped.
        issue(2'd2, 7'd5, 7'd31, 7'd0, 32'd0, 32'd321412, 32'd0, t0);
        wait_idle(100);
        check("t2_idle_cycle", cyc, t0 + 16);

        // Zero notes.
        issue(2'd0, 7'd28, 7'd28, 7'd28, 32'd0, 32'd0, 32'd0, t0);
        wait_idle(10);
        check("t3_idle_cycle", cyc, t0 + 2);

        // Abort mid-PLAY of note 1.
        @(negedge clk);
        note_num = 2'd3; note_id_0 = 7'd28; note_id_1 = 7'd37; note_id_2 = 7'd39;
        start = 1'b1;
        t0 = cyc;
        np_q.push_back('{t0 + 2, 32'd382225});
        np_q.push_back('{t0 + 15, 32'd227272});
        tone_q.push_back(8);
        tone_q.push_back(4);
        @(negedge clk);
        start = 1'b0;
        wait_until(t0 + 18);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        check("t4_abort_busy", busy, 0);
        check("t4_abort_tone", tone_en, 0);
        check("t4_abort_done", done, 0);
        repeat (3) @(negedge clk);
        check("t4_stays_idle", busy, 0);
        issue(2'd3, 7'd28, 7'd37, 7'd39, 32'd382225, 32'd227272, 32'd202477, t0);
        wait_idle(100);
        check("t4_replay_idle", cyc, t0 + 41);

        // Restart and ID changes while busy are ignored.
        issue(2'd2, 7'd29, 7'd35, 7'd0, 32'd360773, 32'd255105, 32'd0, t0);
        wait_until(t0 + 11);
        note_num = 2'd3; note_id_0 = 7'd39; note_id_1 = 7'd39; note_id_2 = 7'd39;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_idle(100);
        check("t5_idle_cycle", cyc, t0 + 28);

        // Reset mid-PLAY.
        @(negedge clk);
        note_num = 2'd1; note_id_0 = 7'd28;
        start = 1'b1;
        t0 = cyc;
        np_q.push_back('{t0 + 2, 32'd382225});
        tone_q.push_back(4);
        @(negedge clk);
        start = 1'b0;
        wait_until(t0 + 5);
        rst = 1'b1;
        @(negedge clk);
        check("t5_rst_clks", clks_per_period, 0);
        check("t5_rst_tone", tone_en, 0);
        check("t5_rst_busy", busy, 0);
        check("t5_rst_np", new_period, 0);
        check("t5_rst_done", done, 0);
        check("t5_rst_idx", cur_idx, 0);
        rst = 1'b0;
        @(negedge clk);

`ifdef SEQ_LOOP_EN
        // Looping single note: one pass is LOAD + PLAY + GAP = 13 cycles.
        loop_en = 1'b1;
        @(negedge clk);
        note_num = 2'd1; note_id_0 = 7'd28;
        start = 1'b1;
        t0 = cyc;
        for (int k = 0; k < 3; k++) begin
            np_q.push_back('{t0 + 2 + 13 * k, 32'd382225});
            tone_q.push_back(8);
        end
        done_q.push_back(t0 + 40);
        @(negedge clk);
        start = 1'b0;
        wait_until(t0 + 30);
        loop_en = 1'b0;
        wait_idle(100);
        check("t6_idle_cycle", cyc, t0 + 41);
`endif

        repeat (5) @(negedge clk);
        check("np_q_drained", np_q.size(), 0);
        check("done_q_drained", done_q.size(), 0);
        check("tone_q_drained", tone_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
